// File: rtl/stream_frame_loader.sv
// stream_frame_loader: assembles an MSB-first serial bit stream into 32-bit
// words and groups them into frames of N words.
// Ports:
//   clk, reset (async, active-low)
//   s_sync / s_valid / s_bit : frame-start strobe, bit qualifier, serial data
//   d_ready                  : downstream accepts d_out
//   clr_flags                : synchronous clear of overflow / sync_err
//   d_out / d_valid          : assembled word and its valid flag
//   frame_last               : d_out is the final word of its frame
//   frame_done               : one-cycle pulse when the final word completes
//   word_cnt                 : words completed in the current frame
//   overflow / sync_err      : sticky error flags
module stream_frame_loader #(
    parameter int unsigned N = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sync,
    input  logic        s_valid,
    input  logic        s_bit,
    input  logic        d_ready,
    input  logic        clr_flags,
    output logic [31:0] d_out,
    output logic        d_valid,
    output logic        frame_last,
    output logic        frame_done,
    output logic [7:0]  word_cnt,
    output logic        overflow,
    output logic        sync_err
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SHIFT_W = WORD_W - 1;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_nxt;

    // Only the partial word is stored; the 32nd bit is taken straight from s_bit.
    logic [SHIFT_W-1:0] shift_q, shift_nxt;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
    logic [CNT_W-1:0]   word_cnt_nxt;
    logic [WORD_W-1:0]  d_out_nxt;
    logic               d_valid_nxt, frame_last_nxt, frame_done_nxt;
    logic               overflow_nxt, sync_err_nxt;

    logic               take_bit, word_done, last_word;
    logic [WORD_W-1:0]  word_val;

    // A bit is shifted only while running and not being resynchronised.
    assign take_bit  = (state == RUN) && s_valid && !s_sync;
    assign word_done = take_bit && (bit_cnt_q == BIT_W'(WORD_W - 1));
    assign last_word = word_done && (word_cnt == LAST_WORD);
    assign word_val  = {shift_q, s_bit};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: sync always (re)starts a frame, final word ends it
    always_comb begin
        state_nxt = state;
        if (s_sync) begin
            state_nxt = RUN;
        end else if (last_word) begin
            state_nxt = IDLE;
        end
    end

    // Output / datapath next values
    always_comb begin
        shift_nxt      = shift_q;
        bit_cnt_nxt    = bit_cnt_q;
        word_cnt_nxt   = word_cnt;
        d_out_nxt      = d_out;
        d_valid_nxt    = d_valid;
        frame_last_nxt = frame_last;
        frame_done_nxt = 1'b0;
        overflow_nxt   = overflow & ~clr_flags;
        sync_err_nxt   = sync_err & ~clr_flags;

        if (s_sync) begin
            if ((state == RUN) && ((bit_cnt_q != '0) || (word_cnt != '0))) begin
                sync_err_nxt = 1'b1;
            end
            word_cnt_nxt = '0;
            shift_nxt    = s_valid ? SHIFT_W'(s_bit) : '0;
            bit_cnt_nxt  = s_valid ? BIT_W'(1) : '0;
        end else if (take_bit) begin
            shift_nxt   = word_val[SHIFT_W-1:0];
            bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
            if (word_done) begin
                word_cnt_nxt   = last_word ? '0 : word_cnt + CNT_W'(1);
                frame_done_nxt = last_word;
            end
        end

        // Output register: load, drop on back-pressure, or retire
        if (word_done) begin
            if (!d_valid || d_ready) begin
                d_out_nxt      = word_val;
                d_valid_nxt    = 1'b1;
                frame_last_nxt = last_word;
            end else begin
                overflow_nxt = 1'b1;
            end
        end else if (d_valid && d_ready) begin
            d_valid_nxt = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt   <= '0;
            d_out      <= '0;
            d_valid    <= 1'b0;
            frame_last <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            shift_q    <= shift_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            d_out      <= d_out_nxt;
            d_valid    <= d_valid_nxt;
            frame_last <= frame_last_nxt;
            frame_done <= frame_done_nxt;
            overflow   <= overflow_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_stream_frame_loader.sv
// Testbench for stream_frame_loader: an N=4 and an N=32 instance share one
// stimulus stream; each is compared every cycle against a word-level model.
module tb_stream_frame_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_sync = 1'b0, s_valid = 1'b0, s_bit = 1'b0;
    logic d_ready = 1'b1, clr_flags = 1'b0;

    logic [31:0] d_out4, d_out32;
    logic        d_valid4, d_valid32, frame_last4, frame_last32;
    logic        frame_done4, frame_done32, overflow4, overflow32;
    logic        sync_err4, sync_err32;
    logic [7:0]  word_cnt4, word_cnt32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_frame_loader #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .s_sync(s_sync), .s_valid(s_valid),
        .s_bit(s_bit), .d_ready(d_ready), .clr_flags(clr_flags),
        .d_out(d_out4), .d_valid(d_valid4), .frame_last(frame_last4),
        .frame_done(frame_done4), .word_cnt(word_cnt4),
        .overflow(overflow4), .sync_err(sync_err4)
    );

    stream_frame_loader #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .s_sync(s_sync), .s_valid(s_valid),
        .s_bit(s_bit), .d_ready(d_ready), .clr_flags(clr_flags),
        .d_out(d_out32), .d_valid(d_valid32), .frame_last(frame_last32),
        .frame_done(frame_done32), .word_cnt(word_cnt32),
        .overflow(overflow32), .sync_err(sync_err32)
    );

    // Word-level model: bits collected so far, words done in the frame,
    // and what the output register must hold.
    typedef struct {
        bit        run;
        int        nbits;
        bit [31:0] acc;
        int        wc;
        bit        dv;
        bit [31:0] dout;
        bit        last;
        bit        done;
        bit        ov;
        bit        se;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r.run = 0; r.nbits = 0; r.acc = 0; r.wc = 0; r.dv = 0;
        r.dout = 0; r.last = 0; r.done = 0; r.ov = 0; r.se = 0;
        return r;
    endfunction

    function automatic model_t step(model_t m, int n, bit sync, bit valid,
                                    bit sbit, bit ready, bit clr);
        model_t    r = m;
        bit        got = 0;
        bit        lst = 0;
        bit [31:0] w = 0;
        bit        set_ov = 0;
        bit        set_se = 0;
        r.done = 0;
        if (sync) begin
            set_se  = m.run && (m.nbits != 0 || m.wc != 0);
            r.run   = 1;
            r.wc    = 0;
            r.nbits = valid ? 1 : 0;
            r.acc   = valid ? 32'(sbit) : 32'd0;
        end else if (m.run && valid) begin
            r.acc   = m.acc * 2 + 32'(sbit);
            r.nbits = m.nbits + 1;
            if (r.nbits == 32) begin
                got     = 1;
                w       = r.acc;
                lst     = (m.wc == n - 1);
                r.nbits = 0;
                r.acc   = 0;
                if (lst) begin
                    r.wc = 0; r.run = 0; r.done = 1;
                end else begin
                    r.wc = m.wc + 1;
                end
            end
        end
        if (got) begin
            if (!m.dv || ready) begin
                r.dv = 1; r.dout = w; r.last = lst;
            end else begin
                set_ov = 1;
            end
        end else if (m.dv && ready) begin
            r.dv = 0;
        end
        r.ov = set_ov | (m.ov & !clr);
        r.se = set_se | (m.se & !clr);
        return r;
    endfunction

    model_t m4  = model_reset();
    model_t m32 = model_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m4  <= model_reset();
            m32 <= model_reset();
        end else begin
            m4  <= step(m4, 4, s_sync, s_valid, s_bit, d_ready, clr_flags);
            m32 <= step(m32, 32, s_sync, s_valid, s_bit, d_ready, clr_flags);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input model_t m, input logic [31:0] dout,
                       input logic dv, input logic fl, input logic fd,
                       input logic [7:0] wc, input logic ov, input logic se);
        chk({tag, " d_valid"}, 32'(dv), 32'(m.dv));
        if (m.dv) begin
            chk({tag, " d_out"}, dout, m.dout);
            chk({tag, " frame_last"}, 32'(fl), 32'(m.last));
        end
        chk({tag, " frame_done"}, 32'(fd), 32'(m.done));
        chk({tag, " word_cnt"}, 32'(wc), 32'(m.wc));
        chk({tag, " overflow"}, 32'(ov), 32'(m.ov));
        chk({tag, " sync_err"}, 32'(se), 32'(m.se));
    endtask

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        cmp("n4", m4, d_out4, d_valid4, frame_last4, frame_done4, word_cnt4, overflow4, sync_err4);
        cmp("n32", m32, d_out32, d_valid32, frame_last32, frame_done32, word_cnt32, overflow32, sync_err32);
    end

    // One input cycle; returns 1ns after the sampling edge
    task automatic cyc(input logic sync, input logic valid, input logic b);
        s_sync = sync; s_valid = valid; s_bit = b;
        @(posedge clk);
        #1;
        s_sync = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic sync_first);
        for (int i = 31; i >= 0; i--) cyc(sync_first && (i == 31), 1'b1, w[i]);
    endtask

    logic [31:0] words4 [4];
    logic [31:0] w;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst d_valid", 32'(d_valid4), 32'd0);
        chk("rst d_out", d_out4, 32'd0);
        chk("rst word_cnt", 32'(word_cnt4), 32'd0);
        chk("rst flags", {30'd0, overflow4, sync_err4}, 32'd0);
        chk("rst last/done", {30'd0, frame_last32, frame_done32}, 32'd0);
        reset = 1'b1;

        // Idle: toggling s_valid without sync is ignored
        for (int i = 0; i < 40; i++) cyc(1'b0, i[0], 1'($urandom));
        chk("idle d_valid", 32'(d_valid4 | d_valid32), 32'd0);
        chk("idle word_cnt", 32'(word_cnt4 | word_cnt32), 32'd0);

        // Full N=4 frame, contiguous bits, d_ready=1
        words4 = '{32'hDEADBEEF, 32'd1, 32'd2, 32'hFFFFFFFF};
        for (int k = 0; k < 4; k++) begin
            w = words4[k];
            for (int i = 31; i >= 0; i--) begin
                cyc((k == 0) && (i == 31), 1'b1, w[i]);
                if (i == 1) chk("pre-word d_valid", 32'(d_valid4), 32'd0);
            end
            chk("frame d_out", d_out4, w);
            chk("frame d_valid", 32'(d_valid4), 32'd1);
            chk("frame last", 32'(frame_last4), 32'(k == 3));
            chk("frame done", 32'(frame_done4), 32'(k == 3));
            chk("frame word_cnt", 32'(word_cnt4), (k == 3) ? 32'd0 : 32'(k + 1));
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("post d_valid", 32'(d_valid4), 32'd0);
        chk("post done", 32'(frame_done4), 32'd0);
        send_word(32'hCAFEF00D, 1'b0);
        chk("back idle d_valid", 32'(d_valid4), 32'd0);
        chk("back idle word_cnt", 32'(word_cnt4), 32'd0);

        // Back-pressure drop
        d_ready = 1'b0;
        send_word(32'hA5A5A5A5, 1'b1);
        send_word(32'h12345678, 1'b0);
        chk("bp d_out", d_out4, 32'hA5A5A5A5);
        chk("bp d_valid", 32'(d_valid4), 32'd1);
        chk("bp overflow", 32'(overflow4), 32'd1);
        chk("bp word_cnt", 32'(word_cnt4), 32'd2);
        chk("sync at boundary", 32'(sync_err4), 32'd0);
        clr_flags = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0;
        chk("clr overflow", 32'(overflow4), 32'd0);
        chk("clr held d_out", d_out4, 32'hA5A5A5A5);
        d_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("drain d_valid", 32'(d_valid4), 32'd0);

        // Resync mid-frame and mid-word
        send_word(32'h0BADF00D, 1'b1);
        chk("resync err", 32'(sync_err4), 32'd1);
        chk("resync word_cnt", 32'(word_cnt4), 32'd1);
        chk("resync d_out", d_out4, 32'h0BADF00D);
        clr_flags = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0;
        chk("clr sync_err", 32'(sync_err4), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'($urandom));
        w = 32'h3C3C5A5A;
        clr_flags = 1'b1;
        cyc(1'b1, 1'b1, w[31]);
        clr_flags = 1'b0;
        chk("set beats clr", 32'(sync_err4), 32'd1);
        chk("resync cnt clear", 32'(word_cnt4), 32'd0);
        for (int i = 30; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
        chk("resync word0", d_out4, 32'h3C3C5A5A);
        chk("resync word0 cnt", 32'(word_cnt4), 32'd1);

        // Reset mid-word discards partial data
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        chk("async rst d_valid", 32'(d_valid4), 32'd0);
        chk("async rst flags", {30'd0, overflow4, sync_err4}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_word(32'hFFFFFFFF, 1'b0);
        chk("no sync after rst", 32'(d_valid4), 32'd0);
        send_word(32'h00000001, 1'b1);
        chk("rst clean d_out", d_out4, 32'h00000001);
        chk("rst clean flags", {30'd0, overflow4, sync_err4}, 32'd0);

        // Randomised gaps, back-pressure and occasional resync
        for (int e = 0; e < 3; e++) begin
            d_ready = 1'b1;
            cyc(1'b1, 1'b1, 1'($urandom));
            for (int c = 0; c < 1500; c++) begin
                d_ready   = ($urandom_range(0, 9) < 7);
                clr_flags = ($urandom_range(0, 49) == 0);
                cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
            end
        end
        clr_flags = 1'b0;
        d_ready   = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
